// File: rtl/alu_iter.sv
// alu_iter: execute-stage ALU with single-cycle integer ops and iterative shift-add multiply.
// Define ALU_ITER_DIV_EN to build in the restoring divider (ops 14-17); otherwise they report err.
module alu_iter #(
    parameter int XLEN = 32
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_kill,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_err
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_ITER_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_next, w_dispatch;
    logic [SHW-1:0]    r_step;
    logic [XLEN-1:0]   r_hi, r_lo, r_opd;
    logic              r_neg_lo, r_op_hi;
    logic [XLEN-1:0]   r_result;
    logic              r_err;

    logic              w_in_ready, w_accept, w_is_mul, w_is_long;
    logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic [XLEN-1:0]   w_simple_res;
    logic              w_simple_err;

    assign w_in_ready = ((r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready)) && !i_kill;
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_is_mul   = (i_op >= OP_MUL) && (i_op <= OP_MULHU);

    assign w_a_signed = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU)
                     || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_b_signed = (i_op == OP_MUL) || (i_op == OP_MULH)
                     || (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_a_neg    = w_a_signed && i_a[XLEN-1];
    assign w_b_neg    = w_b_signed && i_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -i_a : i_a;
    assign w_b_mag    = w_b_neg ? -i_b : i_b;

    always_comb begin
        w_simple_res = '0;
        w_simple_err = 1'b0;
        case (i_op)
            OP_ADD:  w_simple_res = i_a + i_b;
            OP_SUB:  w_simple_res = i_a - i_b;
            OP_SLL:  w_simple_res = i_a << i_b[SHW-1:0];
            OP_SLT:  w_simple_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: w_simple_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            OP_XOR:  w_simple_res = i_a ^ i_b;
            OP_SRL:  w_simple_res = i_a >> i_b[SHW-1:0];
            OP_SRA:  w_simple_res = $signed(i_a) >>> i_b[SHW-1:0];
            OP_OR:   w_simple_res = i_a | i_b;
            OP_AND:  w_simple_res = i_a & i_b;
            default: w_simple_err = 1'b1;
        endcase
    end

    // Multiply step: {carry, hi, lo} shifts right once per cycle, lo starts as the multiplier.
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_mul_hi, w_mul_lo, w_mul_res;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    assign w_sum      = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opd : '0)};
    assign w_mul_hi   = w_sum[XLEN:1];
    assign w_mul_lo   = {w_sum[0], r_lo[XLEN-1:1]};
    assign w_prod     = {w_mul_hi, w_mul_lo};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    assign w_mul_res  = r_op_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];

`ifdef ALU_ITER_DIV_EN
    // Restoring divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    logic              w_is_div, w_b_zero, w_ge;
    logic              r_neg_hi;
    logic [XLEN:0]     w_rs;
    logic [XLEN-1:0]   w_sub, w_div_hi, w_div_lo, w_q_fix, w_r_fix, w_div_res;

    assign w_is_div  = (i_op >= OP_DIV) && (i_op <= OP_REMU);
    assign w_b_zero  = (i_b == '0);
    assign w_is_long = w_is_mul || w_is_div;
    assign w_rs      = {r_hi, r_lo[XLEN-1]};
    assign w_ge      = (w_rs >= {1'b0, r_opd});
    assign w_sub     = XLEN'(w_rs - {1'b0, r_opd});
    assign w_div_hi  = w_ge ? w_sub : w_rs[XLEN-1:0];
    assign w_div_lo  = {r_lo[XLEN-2:0], w_ge};
    assign w_q_fix   = r_neg_lo ? -w_div_lo : w_div_lo;
    assign w_r_fix   = r_neg_hi ? -w_div_hi : w_div_hi;
    assign w_div_res = r_op_hi ? w_r_fix : w_q_fix;
`else
    assign w_is_long = w_is_mul;
`endif

    always_comb begin
        w_state_next = r_state;
        w_dispatch   = S_DONE;
        if (w_is_mul) w_dispatch = S_MUL;
`ifdef ALU_ITER_DIV_EN
        if (w_is_div) w_dispatch = S_DIV;
`endif
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_dispatch;
            S_MUL:  if (r_step == '0) w_state_next = S_DONE;
`ifdef ALU_ITER_DIV_EN
            S_DIV:  if (r_step == '0) w_state_next = S_DONE;
`endif
            S_DONE: begin
                if (w_accept)         w_state_next = w_dispatch;
                else if (i_out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (i_kill) w_state_next = S_IDLE;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_step   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_neg_lo <= 1'b0;
            r_op_hi  <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            r_neg_hi <= 1'b0;
`endif
        end else if (w_accept) begin
            r_step  <= SHW'(XLEN-1);
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_opd   <= w_b_mag;
            // High half for MULH*, remainder for REM*.
            r_op_hi <= (i_op != OP_MUL) && (i_op != OP_DIV) && (i_op != OP_DIVU);
`ifdef ALU_ITER_DIV_EN
            r_neg_lo <= (w_a_neg ^ w_b_neg) && !(w_is_div && w_b_zero);
            r_neg_hi <= w_a_neg;
`else
            r_neg_lo <= w_a_neg ^ w_b_neg;
`endif
            if (!w_is_long) begin
                r_result <= w_simple_res;
                r_err    <= w_simple_err;
            end
        end else if (!i_kill && (r_state == S_MUL)) begin
            r_hi   <= w_mul_hi;
            r_lo   <= w_mul_lo;
            r_step <= r_step - SHW'(1);
            if (r_step == '0) begin
                r_result <= w_mul_res;
                r_err    <= 1'b0;
            end
`ifdef ALU_ITER_DIV_EN
        end else if (!i_kill && (r_state == S_DIV)) begin
            r_hi   <= w_div_hi;
            r_lo   <= w_div_lo;
            r_step <= r_step - SHW'(1);
            if (r_step == '0) begin
                r_result <= w_div_res;
                r_err    <= 1'b0;
            end
`endif
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_err       = r_err;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed stimulus for alu_iter with a queue scoreboard fed on accept and drained on output.
// Divide checks follow ALU_ITER_DIV_EN the same way the design does.
module tb_alu_iter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            kill = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [4:0]      op = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            in_ready, out_valid, err;
    logic [XLEN-1:0] result;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] sb_q[$];
    logic [32:0] mon_exp;

    alu_iter #(.XLEN(XLEN)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_kill     (kill),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_result   (result),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // Reference model built on 64-bit arithmetic, returns {err, result}.
    function automatic logic [32:0] golden(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] r;
        logic        e;
        longint      sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e = 1'b0;
        r = '0;
        p = '0;
        case (o)
            5'd0:  r = x + y;
            5'd1:  r = x - y;
            5'd2:  r = x << y[4:0];
            5'd3:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            5'd4:  r = (x < y) ? 32'd1 : 32'd0;
            5'd5:  r = x ^ y;
            5'd6:  r = x >> y[4:0];
            5'd7:  r = $signed(x) >>> y[4:0];
            5'd8:  r = x | y;
            5'd9:  r = x & y;
            5'd10: begin p = 64'(sx * sy); r = p[31:0]; end
            5'd11: begin p = 64'(sx * sy); r = p[63:32]; end
            5'd12: begin p = 64'(sx * longint'({32'b0, y})); r = p[63:32]; end
            5'd13: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
`ifdef ALU_ITER_DIV_EN
            5'd14: r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
            5'd15: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd16: r = (y == 0) ? x : 32'(sx % sy);
            5'd17: r = (y == 0) ? x : x % y;
`endif
            default: begin e = 1'b1; r = '0; end
        endcase
        return {e, r};
    endfunction

    function automatic int lat_of(input logic [4:0] o);
        if (o >= 5'd10 && o <= 5'd13) return XLEN + 1;
`ifdef ALU_ITER_DIV_EN
        if (o >= 5'd14 && o <= 5'd17) return XLEN + 1;
`endif
        return 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: drain on a result handshake, then push on an accept in the same cycle.
    always @(negedge clk) begin
        if (rst || kill) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("result", {31'b0, err, result}, {31'b0, mon_exp});
                    $display("txn result=%h err=%b expected=%h err=%b", result, err, mon_exp[31:0], mon_exp[32]);
                end
            end
            if (in_valid && in_ready) sb_q.push_back(golden(op, a, b));
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the result is taken.
    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(lat_of(o)));
        @(posedge clk); #1;
    endtask

    task automatic long_op_then_abort(input bit use_reset);
        int seen;
`ifdef ALU_ITER_DIV_EN
        op = 5'd14; a = -32'sd100; b = 32'd7;
`else
        op = 5'd10; a = -32'sd100; b = 32'd7;
`endif
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("abort_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (use_reset) rst = 1'b1; else kill = 1'b1;
        op = 5'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        @(negedge clk);
        if (!use_reset) check("kill_blocks_accept", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0; kill = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        if (use_reset) begin
            check("reset_result", 64'(result), 64'(0));
            check("reset_err", 64'(err), 64'(0));
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", 64'(seen), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] bp_exp;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Single-cycle ops
        issue(5'd0, 32'd5, 32'd7);
        issue(5'd1, 32'd5, 32'd7);
        issue(5'd2, 32'h0000_00F1, 32'hFFFF_FFE4);
        issue(5'd7, 32'h8000_0000, 32'h0000_0024);
        issue(5'd3, 32'hFFFF_FFFF, 32'd1);
        issue(5'd4, 32'hFFFF_FFFF, 32'd1);
        issue(5'd5, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
        issue(5'd6, 32'h8000_0000, 32'h0000_0024);
        issue(5'd8, 32'h1200_0034, 32'h0056_0000);
        issue(5'd9, 32'hF0F0_F0F0, 32'h3C3C_3C3C);

        // Multiply
        issue(5'd13, 32'hFFFF_FFFF, 32'd2);
        issue(5'd11, 32'hFFFF_FFFF, 32'd2);
        issue(5'd10, -32'sd3, 32'd7);
        issue(5'd12, 32'h8000_0001, 32'hFFFF_FFFF);
        issue(5'd11, 32'h8000_0000, 32'h8000_0000);

        // Divide (or illegal when the divider is not built)
`ifdef ALU_ITER_DIV_EN
        issue(5'd14, -32'sd7, 32'd2);
        issue(5'd16, -32'sd7, 32'd2);
        issue(5'd15, 32'd10, 32'd0);
        issue(5'd17, 32'd10, 32'd0);
        issue(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd16, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(5'd14, -32'sd9, 32'd0);
        issue(5'd17, 32'd1000, 32'd7);
`else
        issue(5'd14, 32'd10, 32'd2);
        issue(5'd17, 32'd10, 32'd3);
`endif
        issue(5'd31, 32'd10, 32'd2);
        issue(5'd18, 32'd1, 32'd1);

        // Backpressure: hold the result five cycles, then stream ten ADDs
        op = 5'd0; a = 32'h0000_1234; b = 32'h0000_1111; in_valid = 1'b1; out_ready = 1'b0;
        bp_exp = golden(op, a, b);
        @(negedge clk);
        check("bp_accept", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_stable", {31'b0, err, result}, {31'b0, bp_exp});
            check("bp_in_ready", 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = 5'd0; a = 32'(i * 1000); b = 32'(i + 77);
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'(1));
            check("stream_out_valid", 64'(out_valid), 64'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("stream_drained", 64'(out_valid), 64'(0));
        @(posedge clk); #1;

        // Abort mid-operation with kill, then with reset
        issue(5'd0, 32'd100, 32'd23);
        long_op_then_abort(1'b0);
        issue(5'd0, 32'd100, 32'd23);
        long_op_then_abort(1'b1);
        issue(5'd1, 32'd50, 32'd8);

        check("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
